// File: rtl/fiber_pkg.sv
// Shared request-type encodings and helpers for fiberBank and its PE-side arbiter.
package fiber_pkg;

  localparam logic [3:0] FETCH_REQ   = 4'b0001;
  localparam logic [3:0] READ_REQ    = 4'b0010;
  localparam logic [3:0] WRITE_REQ   = 4'b0100;
  localparam logic [3:0] CONSUME_REQ = 4'b1000;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // READ and CONSUME are the only requests that produce one data word back.
  function automatic logic is_resp_type(input logic [3:0] req_type);
    return (req_type == READ_REQ) || (req_type == CONSUME_REQ);
  endfunction

endpackage

// File: rtl/fiber_id_fifo.sv
// Requester-ID FIFO that remembers which PE owns each outstanding bank response.
module fiber_id_fifo #(
  parameter int ID_W  = 2,
  parameter int DEPTH = 4
) (
  input  logic            i_clk,
  input  logic            i_nreset,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [ID_W-1:0] i_din,
  output logic [ID_W-1:0] o_dout,
  output logic            o_empty,
  output logic            o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [ID_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_empty   = (r_count == (PTR_W+1)'(0));
  assign o_full    = (r_count == FULL_CNT);
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_pop_ok  = i_pop & ~o_empty;
  // A push into a full FIFO is only legal when a slot frees up in the same cycle.
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  // Storage, pointers and occupancy count.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= ID_W'(0);
      end
      r_wr_ptr <= PTR_W'(0);
      r_rd_ptr <= PTR_W'(0);
      r_count  <= (PTR_W+1)'(0);
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fiber_bank_arbiter.sv
// Round-robin arbiter sharing one fiberBank PE port between NUM_PE requesters.
// Define FIBER_ARB_FETCH_PRIO_EN to favour FETCH requesters during arbitration.
module fiber_bank_arbiter
  import fiber_pkg::*;
#(
  parameter int NUM_PE     = 4,
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 16,
  parameter int RESP_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_nreset,
  input  logic [NUM_PE*4-1:0]          i_pe_request_type,
  input  logic [NUM_PE*ADDR_WIDTH-1:0] i_pe_addr,
  input  logic [NUM_PE*DATA_WIDTH-1:0] i_pe_data,
  input  logic [NUM_PE-1:0]            i_pe_type_valid,
  output logic [NUM_PE-1:0]            o_pe_type_ready,
  output logic [DATA_WIDTH-1:0]        o_pe_data_o,
  output logic [NUM_PE-1:0]            o_pe_data_o_valid,
  input  logic [NUM_PE-1:0]            i_pe_data_o_ready,
  output logic [3:0]                   o_bank_request_type,
  output logic [ADDR_WIDTH-1:0]        o_bank_addr,
  output logic [DATA_WIDTH-1:0]        o_bank_data,
  output logic                         o_bank_type_valid,
  input  logic                         i_bank_type_ready,
  input  logic [DATA_WIDTH-1:0]        i_bank_data_o,
  input  logic                         i_bank_data_o_valid,
  output logic                         o_bank_data_o_ready
);

  localparam int ID_W = $clog2(NUM_PE);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_PE - 1);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [ID_W-1:0]   r_grant;
  logic [ID_W-1:0]   w_grant_nxt;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   w_rr_ptr_nxt;
  logic [NUM_PE-1:0] w_cand;
  logic [3:0]        w_win_type;
  logic              w_win_resp;
  logic              w_bank_valid;
  logic              w_handshake;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [ID_W-1:0]   w_head;

  // First requester at or after ptr, wrapping modulo NUM_PE.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_PE-1:0] req,
                                              input logic [ID_W-1:0]   ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_PE; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_PE);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

`ifdef FIBER_ARB_FETCH_PRIO_EN
  logic [NUM_PE-1:0] w_fetch;

  // Restrict the candidate set to FETCH requesters whenever any are present.
  always_comb begin
    w_fetch = {NUM_PE{1'b0}};
    for (int p = 0; p < NUM_PE; p++) begin
      w_fetch[p] = i_pe_type_valid[p] & (i_pe_request_type[p*4 +: 4] == FETCH_REQ);
    end
    if (|w_fetch) begin
      w_cand = w_fetch;
    end else begin
      w_cand = i_pe_type_valid;
    end
  end
`else
  assign w_cand = i_pe_type_valid;
`endif

  assign w_win_type = i_pe_request_type[int'(r_grant)*4 +: 4];
  assign w_win_resp = is_resp_type(w_win_type);
  // A data-returning request stalls only when no ID slot exists or frees this cycle.
  assign w_bank_valid = (r_state == HOLD) & ~(w_win_resp & w_fifo_full & ~w_pop);
  assign w_handshake  = w_bank_valid & i_bank_type_ready;
  assign w_push       = w_handshake & w_win_resp;
  assign w_pop        = i_bank_data_o_valid & o_bank_data_o_ready;

  fiber_id_fifo #(
    .ID_W (ID_W),
    .DEPTH(RESP_DEPTH)
  ) u_id_fifo (
    .i_clk   (i_clk),
    .i_nreset(i_nreset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (r_grant),
    .o_dout  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full)
  );

  // FSM state, granted requester and round-robin pointer.
  always_ff @(posedge i_clk or negedge i_nreset) begin
    if (!i_nreset) begin
      r_state  <= ARB;
      r_grant  <= ID_W'(0);
      r_rr_ptr <= ID_W'(0);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next-state: pick a winner in ARB, release it after the bank handshake in HOLD.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    case (r_state)
      ARB: begin
        if (|i_pe_type_valid) begin
          w_grant_nxt = rr_pick(w_cand, r_rr_ptr);
          w_state_nxt = HOLD;
        end else begin
          w_state_nxt = ARB;
        end
      end
      HOLD: begin
        if (w_handshake) begin
          w_rr_ptr_nxt = (r_grant == LAST_ID) ? ID_W'(0) : r_grant + ID_W'(1);
          w_state_nxt  = ARB;
        end else begin
          w_state_nxt = HOLD;
        end
      end
      default: w_state_nxt = ARB;
    endcase
  end

  // Request path: winner's lanes pass straight through to the bank while held.
  always_comb begin
    o_bank_request_type = 4'b0000;
    o_bank_addr         = {ADDR_WIDTH{1'b0}};
    o_bank_data         = {DATA_WIDTH{1'b0}};
    o_bank_type_valid   = 1'b0;
    o_pe_type_ready     = {NUM_PE{1'b0}};
    if (r_state == HOLD) begin
      o_bank_request_type      = w_win_type;
      o_bank_addr              = i_pe_addr[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
      o_bank_data              = i_pe_data[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
      o_bank_type_valid        = w_bank_valid;
      o_pe_type_ready[r_grant] = w_handshake;
    end else begin
      o_bank_type_valid = 1'b0;
    end
  end

  // Response path: route bank data to the PE at the head of the ID FIFO.
  always_comb begin
    o_pe_data_o_valid   = {NUM_PE{1'b0}};
    o_bank_data_o_ready = 1'b0;
    o_pe_data_o         = {DATA_WIDTH{1'b0}};
    if (!w_fifo_empty) begin
      o_pe_data_o_valid[w_head] = i_bank_data_o_valid;
      o_bank_data_o_ready       = i_pe_data_o_ready[w_head];
      o_pe_data_o               = i_bank_data_o;
    end else begin
      o_bank_data_o_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_fiber_bank_arbiter.sv
// Directed self-checking bench for fiber_bank_arbiter (4 PEs, RESP_DEPTH 4).
module tb_fiber_bank_arbiter;
  import fiber_pkg::*;

  localparam int NPE = 4;
  localparam int AW  = 64;
  localparam int DW  = 16;

  logic               clk = 1'b0;
  logic               nreset;
  logic [NPE*4-1:0]   pe_type;
  logic [NPE*AW-1:0]  pe_addr;
  logic [NPE*DW-1:0]  pe_data;
  logic [NPE-1:0]     pe_valid;
  logic [NPE-1:0]     pe_ready;
  logic [DW-1:0]      pe_dout;
  logic [NPE-1:0]     pe_dout_valid;
  logic [NPE-1:0]     pe_dout_ready;
  logic [3:0]         bank_type;
  logic [AW-1:0]      bank_addr;
  logic [DW-1:0]      bank_data;
  logic               bank_valid;
  logic               bank_ready;
  logic [DW-1:0]      bank_dout;
  logic               bank_dout_valid;
  logic               bank_dout_ready;

  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] exp_oh;

  fiber_bank_arbiter #(
    .NUM_PE(NPE), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_DEPTH(4)
  ) dut (
    .i_clk              (clk),
    .i_nreset           (nreset),
    .i_pe_request_type  (pe_type),
    .i_pe_addr          (pe_addr),
    .i_pe_data          (pe_data),
    .i_pe_type_valid    (pe_valid),
    .o_pe_type_ready    (pe_ready),
    .o_pe_data_o        (pe_dout),
    .o_pe_data_o_valid  (pe_dout_valid),
    .i_pe_data_o_ready  (pe_dout_ready),
    .o_bank_request_type(bank_type),
    .o_bank_addr        (bank_addr),
    .o_bank_data        (bank_data),
    .o_bank_type_valid  (bank_valid),
    .i_bank_type_ready  (bank_ready),
    .i_bank_data_o      (bank_dout),
    .i_bank_data_o_valid(bank_dout_valid),
    .o_bank_data_o_ready(bank_dout_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_pe(input int p, input logic [3:0] t, input logic [63:0] a,
                        input logic [15:0] d, input logic v);
    pe_type[p*4 +: 4]   = t;
    pe_addr[p*AW +: AW] = a;
    pe_data[p*DW +: DW] = d;
    pe_valid[p]         = v;
  endtask

  task automatic clear_pes();
    pe_type  = '0;
    pe_addr  = '0;
    pe_data  = '0;
    pe_valid = '0;
  endtask

  initial begin
    nreset          = 1'b0;
    clear_pes();
    bank_ready      = 1'b1;
    bank_dout       = 16'hDEAD;
    bank_dout_valid = 1'b1;
    pe_dout_ready   = 4'b1111;
    set_pe(0, READ_REQ, 64'h1, 16'h1, 1'b1);
    tick();
    tick();
    // Reset state
    check("rst_bank_valid", bank_valid, 1'b0);
    check("rst_pe_ready", pe_ready, 4'b0000);
    check("rst_bank_addr", bank_addr, 64'h0);
    check("rst_bank_type", bank_type, 4'b0000);
    check("rst_dout_valid", pe_dout_valid, 4'b0000);
    check("rst_dout", pe_dout, 16'h0);
    check("rst_bank_dout_ready", bank_dout_ready, 1'b0);
    clear_pes();
    bank_dout_valid = 1'b0;
    nreset          = 1'b1;

    // Round-robin fairness with continuous FETCH from all PEs
    for (int p = 0; p < NPE; p++) set_pe(p, FETCH_REQ, 64'(256 + p), 16'(p), 1'b1);
    bank_ready = 1'b1;
    settle();
    check("rr_arb_idle", pe_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      exp_oh = 4'b0001 << (k % 4);
      tick();
      check("rr_ready", pe_ready, exp_oh);
      check("rr_addr", bank_addr, 64'(256 + (k % 4)));
      tick();
      check("rr_gap", pe_ready, 4'b0000);
    end
    clear_pes();

    // Single READ from PE2
    set_pe(2, READ_REQ, 64'h00000000FFFFFFFF, 16'h0, 1'b1);
    bank_ready = 1'b0;
    settle();
    check("rd_lat0", bank_valid, 1'b0);
    tick();
    check("rd_valid", bank_valid, 1'b1);
    check("rd_addr", bank_addr, 64'h00000000FFFFFFFF);
    check("rd_type", bank_type, READ_REQ);
    check("rd_not_ready", pe_ready, 4'b0000);
    bank_ready = 1'b1;
    settle();
    check("rd_ready", pe_ready, 4'b0100);
    tick();
    clear_pes();
    bank_ready      = 1'b0;
    bank_dout       = 16'h1234;
    bank_dout_valid = 1'b1;
    pe_dout_ready   = 4'b1111;
    settle();
    check("rd_resp_valid", pe_dout_valid, 4'b0100);
    check("rd_resp_data", pe_dout, 16'h1234);
    check("rd_resp_ready", bank_dout_ready, 1'b1);
    tick();
    bank_dout_valid = 1'b0;
    settle();
    check("rd_fifo_empty", bank_dout_ready, 1'b0);

    // Ordering: PE1 READ then PE3 CONSUME
    set_pe(1, READ_REQ, 64'h11, 16'h0, 1'b1);
    bank_ready = 1'b1;
    tick();
    check("ord_pe1_ready", pe_ready, 4'b0010);
    tick();
    clear_pes();
    set_pe(3, CONSUME_REQ, 64'h33, 16'h0, 1'b1);
    tick();
    check("ord_pe3_ready", pe_ready, 4'b1000);
    check("ord_pe3_type", bank_type, CONSUME_REQ);
    tick();
    clear_pes();
    bank_dout       = 16'hAAAA;
    bank_dout_valid = 1'b1;
    pe_dout_ready   = 4'b1101;
    for (int k = 0; k < 3; k++) begin
      settle();
      check("ord_stall_valid", pe_dout_valid, 4'b0010);
      check("ord_stall_ready", bank_dout_ready, 1'b0);
      tick();
    end
    pe_dout_ready = 4'b1111;
    settle();
    check("ord_a_ready", bank_dout_ready, 1'b1);
    check("ord_a_valid", pe_dout_valid, 4'b0010);
    check("ord_a_data", pe_dout, 16'hAAAA);
    tick();
    bank_dout = 16'hBBBB;
    settle();
    check("ord_b_valid", pe_dout_valid, 4'b1000);
    check("ord_b_data", pe_dout, 16'hBBBB);
    tick();
    bank_dout_valid = 1'b0;
    settle();
    check("ord_empty", bank_dout_ready, 1'b0);

    // FIFO full: four READs outstanding, fifth stalls until a pop
    set_pe(0, READ_REQ, 64'h40, 16'h0, 1'b1);
    bank_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("full_fill_ready", pe_ready, 4'b0001);
      tick();
    end
    tick();
    check("full_stall_valid", bank_valid, 1'b0);
    check("full_stall_ready", pe_ready, 4'b0000);
    tick();
    check("full_stall_valid2", bank_valid, 1'b0);
    bank_dout       = 16'h0001;
    bank_dout_valid = 1'b1;
    settle();
    check("full_pop_valid", bank_valid, 1'b1);
    check("full_pop_ready", pe_ready, 4'b0001);
    check("full_pop_dout", pe_dout_valid, 4'b0001);
    tick();
    bank_dout_valid = 1'b0;
    clear_pes();
    set_pe(1, WRITE_REQ, 64'h55, 16'hCAFE, 1'b1);
    tick();
    check("full_write_valid", bank_valid, 1'b1);
    check("full_write_ready", pe_ready, 4'b0010);
    check("full_write_type", bank_type, WRITE_REQ);
    check("full_write_data", bank_data, 16'hCAFE);
    tick();
    clear_pes();
    bank_dout_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("full_drain", pe_dout_valid, 4'b0001);
      tick();
    end
    bank_dout_valid = 1'b0;
    settle();
    check("full_drained", bank_dout_ready, 1'b0);

    // Reset while PE0 is held with the bank not ready
    set_pe(0, READ_REQ, 64'h77, 16'h0, 1'b1);
    bank_ready = 1'b1;
    tick();
    tick();
    bank_ready = 1'b0;
    tick();
    check("mrst_pre_valid", bank_valid, 1'b1);
    check("mrst_pre_addr", bank_addr, 64'h77);
    nreset = 1'b0;
    settle();
    check("mrst_valid", bank_valid, 1'b0);
    check("mrst_addr", bank_addr, 64'h0);
    check("mrst_type", bank_type, 4'b0000);
    bank_ready      = 1'b1;
    bank_dout       = 16'h5555;
    bank_dout_valid = 1'b1;
    settle();
    check("mrst_pe_ready", pe_ready, 4'b0000);
    check("mrst_dout_valid", pe_dout_valid, 4'b0000);
    check("mrst_dout", pe_dout, 16'h0);
    check("mrst_bank_dout_ready", bank_dout_ready, 1'b0);
    tick();
    nreset = 1'b1;
    clear_pes();
    settle();
    check("stray_valid", pe_dout_valid, 4'b0000);
    check("stray_ready", bank_dout_ready, 1'b0);
    tick();
    check("stray_ready2", bank_dout_ready, 1'b0);
    bank_dout_valid = 1'b0;
    set_pe(2, READ_REQ, 64'h20, 16'h0, 1'b1);
    tick();
    check("post_rst_ready", pe_ready, 4'b0100);
    tick();
    clear_pes();
    bank_dout       = 16'h2222;
    bank_dout_valid = 1'b1;
    settle();
    check("post_rst_resp", pe_dout_valid, 4'b0100);
    check("post_rst_data", pe_dout, 16'h2222);
    tick();
    bank_dout_valid = 1'b0;

    // PE0 READ vs PE1 FETCH from rr_ptr 0
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    set_pe(0, READ_REQ, 64'h0, 16'h0, 1'b1);
    set_pe(1, FETCH_REQ, 64'h1, 16'h0, 1'b1);
    bank_ready = 1'b1;
    tick();
`ifdef FIBER_ARB_FETCH_PRIO_EN
    check("prio_winner", pe_ready, 4'b0010);
`else
    check("prio_winner", pe_ready, 4'b0001);
`endif
    tick();
    clear_pes();
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fiber_bank_arbiter.md
Name: fiber_bank_arbiter

Overview:
- Shares one fiberBank PE-side port between NUM_PE processing-element requesters.
- Round-robin arbitration over request handshakes (FETCH/READ/WRITE/CONSUME).
- Forwards the winner's type, address and write data to the bank.
- Returns read data to the originating PE in order, using an ID FIFO.
- Sits between the PE crossbar and the bank; the DRAM side is untouched.

Parameters:
- NUM_PE, 4, number of requesters (2..16).
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 16, data word width.
- RESP_DEPTH, 4, maximum outstanding data-returning requests (power of 2).
- ID_W, $clog2(NUM_PE), requester ID width (localparam).

Ports:
- i_clk  in  1  clock
- i_nreset  in  1  asynchronous active-low reset
- i_pe_request_type  in  NUM_PE*4  one-hot request type per PE
- i_pe_addr  in  NUM_PE*ADDR_WIDTH  address per PE
- i_pe_data  in  NUM_PE*DATA_WIDTH  write data per PE (valid with the request)
- i_pe_type_valid  in  NUM_PE  request valid per PE
- o_pe_type_ready  out  NUM_PE  request accepted per PE
- o_pe_data_o  out  DATA_WIDTH  response data, broadcast to all PEs
- o_pe_data_o_valid  out  NUM_PE  response valid, one-hot to the owning PE
- i_pe_data_o_ready  in  NUM_PE  response ready per PE
- o_bank_request_type  out  4  to bank i_request_type
- o_bank_addr  out  ADDR_WIDTH  to bank i_addr
- o_bank_data  out  DATA_WIDTH  to bank i_data
- o_bank_type_valid  out  1  to bank i_type_valid
- i_bank_type_ready  in  1  from bank o_type_ready
- i_bank_data_o  in  DATA_WIDTH  from bank o_pe_data_o
- i_bank_data_o_valid  in  1  from bank o_pe_data_o_valid
- o_bank_data_o_ready  out  1  to bank i_pe_data_o_ready

Behaviour:
- Clocking and reset: one clock i_clk; i_nreset is asynchronous, active-low.
- Outputs during reset: state=ARB, rr_ptr=0, grant=0, ID FIFO empty.
  - All valid/ready outputs are 0; o_bank_* fields are 0; o_pe_data_o is 0.
- Request types: FETCH=4'b0001, READ=4'b0010, WRITE=4'b0100, CONSUME=4'b1000.
  - READ and CONSUME return exactly one data word ("resp-type").
  - FETCH and WRITE return nothing.
- FSM ARB:
  - If any i_pe_type_valid is set, register winner = first set bit scanning from rr_ptr upward, wrapping modulo NUM_PE.
  - Go to HOLD. With no valid requests, stay in ARB.
- FSM HOLD:
  - Drive o_bank_* from the winner's lanes, combinationally from the inputs.
  - o_bank_type_valid = 1, unless the winner is resp-type and the FIFO is full with no pop this cycle; then it is 0 (stall).
  - o_pe_type_ready[winner] = o_bank_type_valid & i_bank_type_ready. Pass-through, same cycle; all other bits 0.
  - On handshake: push winner ID if resp-type, set rr_ptr = (winner+1) mod NUM_PE, go to ARB.
- Latency: a request reaches the bank 1 cycle after PE valid, best case. Back-to-back grants are therefore every 2 cycles minimum.
- Requester rules: a PE must hold valid, type, addr and data stable until ready.
  - Dropping valid in HOLD is a protocol violation; the arbiter keeps presenting the registered winner's current lanes.
- Response routing:
  - With the FIFO non-empty, head = FIFO head ID.
  - o_pe_data_o_valid[head] = i_bank_data_o_valid.
  - o_bank_data_o_ready = i_pe_data_o_ready[head].
  - o_pe_data_o = i_bank_data_o.
  - Pop on i_bank_data_o_valid & o_bank_data_o_ready.
- Empty FIFO: o_bank_data_o_ready=0 and all o_pe_data_o_valid=0. Bank data arriving in this state is ignored (bank protocol error).
- Simultaneous push and pop: count unchanged, pointers both advance. A push at full is allowed only with a same-cycle pop.
- FIFO pointers: ID_W-independent, log2(RESP_DEPTH) bits, wrap modulo RESP_DEPTH. Count is log2(RESP_DEPTH)+1 bits.
- Reset mid-operation: the grant is dropped and outstanding IDs are discarded. Any bank responses after reset are ignored by the empty-FIFO rule.

Optional Feature:
- Macro: FIBER_ARB_FETCH_PRIO_EN.
- Defined: in ARB, if any valid PE presents FETCH, the winner is chosen round-robin from rr_ptr among FETCH requesters only. Otherwise normal round-robin applies. The rr_ptr update is unchanged.
- Undefined: pure round-robin regardless of request type.

Decomposition:
- Package fiber_pkg holds:
  - the request-type localparams FETCH_REQ, READ_REQ, WRITE_REQ, CONSUME_REQ;
  - the function is_resp_type(type).
  - Shared with fiberBank and benches.
- Sub-module fiber_id_fifo: synchronous FIFO of ID_W-bit entries, RESP_DEPTH deep.
  - Ports: push, pop, din, dout, empty, full.
  - Asynchronous active-low reset.
- Round-robin pick function: inline in the arbiter.

Test Plan:
- Single READ: PE2 READ addr 0x00000000FFFFFFFF → bank sees valid with that addr the cycle after. After handshake, bank returns 16'h1234 → only o_pe_data_o_valid[2]=1 with data 16'h1234. FIFO returns to empty.
- Round-robin fairness: PEs 0..3 issue FETCH continuously → grants in order 0,1,2,3,0. Each o_pe_type_ready pulses once per 2-cycle grant.
- Ordering: PE1 READ then PE3 CONSUME accepted, bank returns 16'hAAAA then 16'hBBBB → PE1 receives AAAA, PE3 receives BBBB. Stalling i_pe_data_o_ready[1] for 3 cycles holds o_bank_data_o_ready=0.
- FIFO full: with RESP_DEPTH=4, four READs outstanding, a fifth READ → o_bank_type_valid=0 until the first pop. In the pop cycle the fifth is accepted, and a WRITE from another PE is not blocked.
- Reset mid-HOLD: assert i_nreset=0 while PE0 is granted with the bank not ready → all outputs 0 asynchronously. After release, a stray bank response is ignored.
- With FIBER_ARB_FETCH_PRIO_EN: PE0 READ and PE1 FETCH both valid, rr_ptr=0 → PE1 is granted first.
